// File: rtl/uart_hex_display.sv
// uart_hex_display
//
// Line editor for hex keystrokes arriving from the UART receive path.
// Hex characters collect in a six-nibble entry buffer. CR commits the
// buffer to the six 7-segment digits, BS removes the newest character,
// and ESC clears the entry and the display. The LEDs show entry status
// and error indications.
//
// Ports:
//   i_clk          system clock, all logic on the rising edge
//   i_rst          synchronous active-high reset
//   i_data_avail   1-cycle strobe, i_din valid in the same cycle
//   i_din[7:0]     received ASCII byte
//   o_seg0..o_seg5 active-low segments {g,f,e,d,c,b,a}, o_seg0 rightmost
//   o_led[9:0]     {overrun, commit toggle, reject count[3:0], pending, count[2:0]}
//
// Each byte takes IDLE -> CLASSIFY -> UPDATE. State and LEDs change on the
// third edge after the strobe; segments follow one edge later.

module uart_hex_display #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_data_avail,
    input  logic [7:0] i_din,
    output logic [6:0] o_seg0,
    output logic [6:0] o_seg1,
    output logic [6:0] o_seg2,
    output logic [6:0] o_seg3,
    output logic [6:0] o_seg4,
    output logic [6:0] o_seg5,
    output logic [9:0] o_led
);

    // No logic depends on the clock frequency; it only has to be sensible.
    if (CLK_HZ < 1) begin : g_clk_hz_invalid
    end

    typedef enum logic [1:0] {IDLE, CLASSIFY, UPDATE} state_t;
    typedef enum logic [2:0] {CLS_DIGIT, CLS_CR, CLS_BS, CLS_ESC, CLS_OTHER} class_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  rx_byte;
    class_t      cls;
    class_t      cls_comb;
    logic [3:0]  nib;
    logic [3:0]  nib_comb;
    logic [23:0] entry;
    logic [23:0] disp;
    logic [2:0]  count;
    logic [5:0]  mask;
    logic [5:0]  count_mask;
    logic        pending;
    logic        commit_t;
    logic        overrun;
    logic [3:0]  rejects;
    logic [3:0]  rejects_inc;
    logic [6:0]  seg [6];

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (i_data_avail) state_next = CLASSIFY;
            CLASSIFY: state_next = UPDATE;
            UPDATE:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Only a strobe seen in IDLE is captured; later ones just flag overrun.
    always_ff @(posedge i_clk) begin
        if (i_rst)                          rx_byte <= 8'h00;
        else if (state == IDLE && i_data_avail) rx_byte <= i_din;
    end

    // Letters map to 10-15 by adding 9 to the low nibble (0x41/0x61 -> 1).
    always_comb begin
        cls_comb = CLS_OTHER;
        nib_comb = 4'h0;
        if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
            cls_comb = CLS_DIGIT;
            nib_comb = rx_byte[3:0];
        end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                     (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
            cls_comb = CLS_DIGIT;
            nib_comb = rx_byte[3:0] + 4'd9;
        end else if (rx_byte == 8'h0D) begin
            cls_comb = CLS_CR;
        end else if (rx_byte == 8'h08) begin
            cls_comb = CLS_BS;
        end else if (rx_byte == 8'h1B) begin
            cls_comb = CLS_ESC;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cls <= CLS_OTHER;
            nib <= 4'h0;
        end else if (state == CLASSIFY) begin
            cls <= cls_comb;
            nib <= nib_comb;
        end
    end

    // Committed digits are the newest `count` nibbles, which sit at the bottom.
    always_comb begin
        count_mask = 6'b0;
        for (int i = 0; i < 6; i++) begin
            if (count > 3'(i)) count_mask[i] = 1'b1;
        end
    end

    assign rejects_inc = (rejects == 4'hF) ? rejects : rejects + 4'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            entry    <= 24'h0;
            count    <= 3'd0;
            disp     <= 24'h0;
            mask     <= 6'b0;
            pending  <= 1'b0;
            commit_t <= 1'b0;
            rejects  <= 4'h0;
        end else if (state == UPDATE) begin
            case (cls)
                CLS_DIGIT: begin
                    if (count != 3'd6) begin
                        entry   <= {entry[19:0], nib};
                        count   <= count + 3'd1;
                        pending <= 1'b1;
                    end else begin
                        rejects <= rejects_inc;
                    end
                end
                CLS_BS: begin
                    if (count != 3'd0) begin
                        entry   <= {4'h0, entry[23:4]};
                        count   <= count - 3'd1;
                        pending <= 1'b1;
                    end else begin
                        rejects <= rejects_inc;
                    end
                end
                CLS_CR: begin
                    disp     <= entry;
                    mask     <= count_mask;
                    count    <= 3'd0;
                    pending  <= 1'b0;
                    commit_t <= ~commit_t;
                end
                CLS_ESC: begin
                    count   <= 3'd0;
                    mask    <= 6'b0;
                    pending <= 1'b0;
                end
                default: rejects <= rejects_inc;
            endcase
        end
    end

    // Reset takes priority, so a strobe coinciding with reset never flags.
    always_ff @(posedge i_clk) begin
        if (i_rst)                               overrun <= 1'b0;
        else if (i_data_avail && state != IDLE)  overrun <= 1'b1;
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 6; i++) begin
            if (i_rst)        seg[i] <= 7'h7F;
            else if (mask[i]) seg[i] <= hex_to_seg(disp[4*i +: 4]);
            else              seg[i] <= 7'h7F;
        end
    end

    assign o_seg0 = seg[0];
    assign o_seg1 = seg[1];
    assign o_seg2 = seg[2];
    assign o_seg3 = seg[3];
    assign o_seg4 = seg[4];
    assign o_seg5 = seg[5];
    assign o_led  = {overrun, commit_t, rejects, pending, count};

endmodule

// File: tb/tb_uart_hex_display.sv
// tb_uart_hex_display
//
// Drives uart_hex_display with directed keystroke sequences followed by a
// randomized byte stream. Expected LEDs and segments come from a queue-based
// model of the line editor. Every byte is checked twice: at the third edge
// (LEDs new, segments still old) and at the fourth edge (segments new).

module tb_uart_hex_display;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_data_avail = 1'b0;
    logic [7:0] i_din = 8'h00;
    logic [6:0] o_seg0, o_seg1, o_seg2, o_seg3, o_seg4, o_seg5;
    logic [9:0] o_led;

    int errors = 0;
    int checks = 0;

    logic [3:0] m_entry [$];
    logic [3:0] m_disp  [6];
    logic       m_valid [6];
    logic       m_pending;
    logic       m_commit;
    logic       m_overrun;
    int         m_rej;

    logic [6:0] seg_table [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    uart_hex_display #(.CLK_HZ(50_000_000)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data_avail (i_data_avail),
        .i_din        (i_din),
        .o_seg0       (o_seg0),
        .o_seg1       (o_seg1),
        .o_seg2       (o_seg2),
        .o_seg3       (o_seg3),
        .o_seg4       (o_seg4),
        .o_seg5       (o_seg5),
        .o_led        (o_led)
    );

    always #5 i_clk = ~i_clk;

    function automatic int hexValue(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
        return -1;
    endfunction

    function automatic void modelReset();
        m_entry.delete();
        for (int i = 0; i < 6; i++) begin
            m_disp[i]  = 4'h0;
            m_valid[i] = 1'b0;
        end
        m_pending = 1'b0;
        m_commit  = 1'b0;
        m_overrun = 1'b0;
        m_rej     = 0;
    endfunction

    function automatic void modelReject();
        if (m_rej < 15) m_rej++;
    endfunction

    function automatic void modelByte(input logic [7:0] b);
        int v;
        int n;
        v = hexValue(b);
        n = m_entry.size();
        if (v >= 0) begin
            if (n < 6) begin
                m_entry.push_back(v[3:0]);
                m_pending = 1'b1;
            end else begin
                modelReject();
            end
        end else if (b == 8'h0D) begin
            for (int i = 0; i < 6; i++) begin
                m_valid[i] = (i < n);
                if (i < n) m_disp[i] = m_entry[n-1-i];
            end
            m_entry.delete();
            m_pending = 1'b0;
            m_commit  = ~m_commit;
        end else if (b == 8'h08) begin
            if (n > 0) begin
                void'(m_entry.pop_back());
                m_pending = 1'b1;
            end else begin
                modelReject();
            end
        end else if (b == 8'h1B) begin
            m_entry.delete();
            for (int i = 0; i < 6; i++) m_valid[i] = 1'b0;
            m_pending = 1'b0;
        end else begin
            modelReject();
        end
    endfunction

    function automatic logic [9:0] expLed();
        logic [3:0] rej;
        rej = 4'(m_rej);
        return {m_overrun, m_commit, rej, m_pending, 3'(m_entry.size())};
    endfunction

    function automatic logic [41:0] expSegs();
        logic [41:0] s;
        s = '0;
        for (int i = 0; i < 6; i++)
            s[7*i +: 7] = m_valid[i] ? seg_table[m_disp[i]] : 7'h7F;
        return s;
    endfunction

    // Compares LEDs against the model and segments against the given value.
    task automatic checkOutput(input string tag, input logic [41:0] want_seg);
        logic [41:0] got_seg;
        logic [9:0]  want_led;
        got_seg  = {o_seg5, o_seg4, o_seg3, o_seg2, o_seg1, o_seg0};
        want_led = expLed();
        checks++;
        assert (o_led === want_led) else begin
            errors++;
            $error("[TB] FAIL %s led observed=%h expected=%h", tag, o_led, want_led);
        end
        checks++;
        assert (got_seg === want_seg) else begin
            errors++;
            $error("[TB] FAIL %s seg observed=%h expected=%h", tag, got_seg, want_seg);
        end
    endtask

    // Strobes b; when gap is 1 or 2 a second byte b2 is strobed that many
    // cycles later and must be dropped. Returns 1 time unit after the third edge.
    task automatic applyStimulus(input logic [7:0] b, input int gap, input logic [7:0] b2);
        i_data_avail = 1'b1;
        i_din        = b;
        @(posedge i_clk);
        #1;
        i_data_avail = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            if (k == gap) begin
                i_data_avail = 1'b1;
                i_din        = b2;
            end
            @(posedge i_clk);
            #1;
            i_data_avail = 1'b0;
        end
    endtask

    task automatic sendByte(input string tag, input logic [7:0] b, input int gap, input logic [7:0] b2);
        logic [41:0] old_seg;
        old_seg = expSegs();
        applyStimulus(b, gap, b2);
        modelByte(b);
        if (gap != 0) m_overrun = 1'b1;
        checkOutput({tag, "@E2"}, old_seg);
        @(posedge i_clk);
        #1;
        checkOutput({tag, "@E3"}, expSegs());
    endtask

    task automatic resetDut(input string tag, input logic with_strobe);
        i_rst        = 1'b1;
        i_data_avail = with_strobe;
        i_din        = 8'h35;
        @(posedge i_clk);
        #1;
        i_data_avail = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        modelReset();
        checkOutput(tag, expSegs());
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    initial begin
        string hexchars;
        logic [7:0] b;
        int r;
        hexchars = "0123456789ABCDEFabcdef";
        modelReset();
        $display("[TB] start");

        // Reset
        resetDut("reset", 1'b0);
        checks++;
        assert (o_led === 10'h000) else begin
            errors++;
            $error("[TB] FAIL reset_led observed=%h expected=%h", o_led, 10'h000);
        end

        // Digit entry and commit
        sendByte("d1", 8'h31, 0, 8'h00);
        idle(6);
        sendByte("d2", 8'h32, 0, 8'h00);
        idle(6);
        sendByte("d3", 8'h33, 0, 8'h00);
        idle(6);
        sendByte("cr1", 8'h0D, 0, 8'h00);
        checks++;
        assert ({o_seg2, o_seg1, o_seg0} === {7'h79, 7'h24, 7'h30}) else begin
            errors++;
            $error("[TB] FAIL cr1_digits observed=%h expected=%h", {o_seg2, o_seg1, o_seg0}, {7'h79, 7'h24, 7'h30});
        end

        // Full buffer and rejects
        sendByte("fa", 8'h41, 0, 8'h00);
        sendByte("fb", 8'h42, 0, 8'h00);
        sendByte("fc", 8'h43, 0, 8'h00);
        sendByte("fd", 8'h44, 0, 8'h00);
        sendByte("fe", 8'h45, 0, 8'h00);
        sendByte("ff", 8'h46, 0, 8'h00);
        sendByte("full7", 8'h37, 0, 8'h00);
        sendByte("other_x", 8'h78, 0, 8'h00);
        sendByte("cr2", 8'h0D, 0, 8'h00);
        checks++;
        assert (o_led[7:4] === 4'd2) else begin
            errors++;
            $error("[TB] FAIL rej_count observed=%0d expected=%0d", o_led[7:4], 2);
        end

        // Backspace and escape
        sendByte("bs_empty", 8'h08, 0, 8'h00);
        sendByte("lf", 8'h66, 0, 8'h00);
        sendByte("le", 8'h65, 0, 8'h00);
        sendByte("bs", 8'h08, 0, 8'h00);
        sendByte("cr3", 8'h0D, 0, 8'h00);
        sendByte("esc", 8'h1B, 0, 8'h00);

        // Overrun: '6' strobed one cycle after '5' is dropped
        sendByte("ovr", 8'h35, 1, 8'h36);
        sendByte("ovr_cr", 8'h0D, 0, 8'h00);
        sendByte("ovr_esc", 8'h1B, 0, 8'h00);
        checks++;
        assert (o_led[9] === 1'b1) else begin
            errors++;
            $error("[TB] FAIL ovr_sticky observed=%b expected=%b", o_led[9], 1'b1);
        end
        sendByte("ovr_gap2", 8'h34, 2, 8'h33);

        // Reset coinciding with a strobe: byte ignored, no overrun
        resetDut("rst_strobe", 1'b1);

        // Reset while a byte is in flight
        i_data_avail = 1'b1;
        i_din        = 8'h39;
        @(posedge i_clk);
        #1;
        i_data_avail = 1'b0;
        i_rst        = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        modelReset();
        checkOutput("rst_mid", expSegs());
        idle(3);
        checkOutput("rst_mid_settle", expSegs());
        sendByte("r9", 8'h39, 0, 8'h00);
        sendByte("r9_cr", 8'h0D, 0, 8'h00);
        checks++;
        assert (o_seg0 === 7'h10) else begin
            errors++;
            $error("[TB] FAIL r9_seg0 observed=%h expected=%h", o_seg0, 7'h10);
        end

        // Randomized byte stream
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 11);
            if (r <= 5)       b = hexchars[$urandom_range(0, 21)];
            else if (r == 6)  b = 8'h0D;
            else if (r == 7)  b = 8'h08;
            else if (r == 8)  b = 8'h1B;
            else              b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0)
                sendByte("rand_ovr", b, int'($urandom_range(1, 2)), 8'($urandom_range(0, 255)));
            else
                sendByte("rand", b, 0, 8'h00);
            idle(int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_hex_display.md
# uart_hex_display

Consumes the byte stream produced by the UART receive path: a 1-cycle data-available strobe plus an 8-bit byte. It interprets the bytes as ASCII hex-entry keystrokes and drives the six 7-segment digits and ten LEDs of the board. The block is a line editor. Hex characters accumulate in an entry buffer, CR commits the buffer to the display, BS deletes the last character, and ESC clears everything. The LEDs show entry status and error indications.

## Interface
- `CLK_HZ`, default 50_000_000. Informational only; no internal timing depends on it.
- `i_clk` in 1: system clock; all logic rises on it.
- `i_rst` in 1: synchronous, active-high reset.
- `i_data_avail` in 1: 1-cycle strobe; `i_din` is valid in the same cycle.
- `i_din` in 8: received ASCII byte.
- `o_seg0`..`o_seg5` out 7 each: active-low segments.
  - Bit order is {g,f,e,d,c,b,a}.
  - `o_seg0` is the rightmost digit.
- `o_led` out 10: status, as defined under Operation.

## Operation
- **Byte classes** (decided on the latched byte):
  - DIGIT: '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66). Value is 0-15.
  - CR: 0x0D. BS: 0x08. ESC: 0x1B. OTHER: any other byte.
- **State**:
  - Entry buffer: 6 nibbles plus `count` (0-6).
  - Committed display: 6 nibbles plus a 6-bit valid mask.
- **FSM**: IDLE → CLASSIFY → UPDATE → IDLE.
  - IDLE: on `i_data_avail`, latch `i_din` and go to CLASSIFY.
  - CLASSIFY: compute class and nibble value; go to UPDATE.
  - UPDATE: apply the action below; go to IDLE.
- **Actions in UPDATE**:
  - DIGIT, count<6: shift the entry buffer left by one nibble; new nibble goes to position 0; count+1; pending=1.
  - DIGIT, count=6: reject; buffer unchanged.
  - BS, count>0: shift right by one nibble; count−1; pending=1.
  - BS, count=0: reject.
  - CR: copy the entry buffer to the display.
    - Valid mask = the low `count` positions.
    - Then set count=0 and pending=0, and toggle `commit_t`.
    - CR with count=0 blanks the display and is not a reject.
  - ESC: count=0, display mask=0, pending=0. Reject counter and overrun flag are unchanged.
  - OTHER: reject.
- **Reject counter**: 4-bit; increments on each reject and saturates at 15.
- **Overrun flag**: sticky; set when `i_data_avail` is high while the FSM is not in IDLE. That byte is dropped.
- **Segment decode** (active-low, registered):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
  - A position with its mask bit clear shows 7F (blank).
- **LED map**:
  - `o_led[2:0]` = count.
  - `o_led[3]` = pending.
  - `o_led[7:4]` = reject counter.
  - `o_led[8]` = `commit_t`.
  - `o_led[9]` = overrun.
- Entry digits are not shown until committed.

## Timing
- **Reset**: `i_rst` has priority over all other activity.
  - FSM → IDLE.
  - Entry buffer, count, mask, pending, `commit_t`, reject counter and overrun all clear.
  - All `o_seg*` = 7'h7F; `o_led` = 0 on the edge after `i_rst` is sampled high.
  - Reset during CLASSIFY or UPDATE discards the in-flight byte with no partial update.
- **Latency**: strobe sampled at edge E0 → CLASSIFY after E0 → UPDATE after E1.
  - Counters, `o_led` and internal state update at E2.
  - `o_seg*` update at E3.
- **Throughput**: the next strobe is accepted at E3 at the earliest (3-cycle minimum spacing). Strobes sampled at E1 or E2 set overrun.
- **Simultaneous strobe and reset**: reset wins; the byte is ignored and overrun is not set.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
1. **Reset**: assert `i_rst` for 2 cycles → all `o_seg*` = 7F, `o_led` = 0.
2. **Digit entry and commit**: send '1','2','3' at 10-cycle spacing.
   - After the digits: `o_led[2:0]`=3, `o_led[3]`=1, segs still 7F.
   - Send CR → seg2/1/0 = 79/24/30, seg5..3 = 7F, `o_led[2:0]`=0, `o_led[3]`=0, `o_led[8]`=1.
   - Seg change occurs exactly 3 edges after the CR strobe edge.
3. **Full buffer and rejects**: send 'A','B','C','D','E','F','7' → count=6, `o_led[7:4]`=1.
   - Send 'x' → `o_led[7:4]`=2.
   - Send CR → seg5..0 = 08/03/46/21/06/0E.
4. **Backspace**: send BS with count=0 → reject count +1.
   - Then send 'f','e',BS,CR → seg0=0E, seg5..1=7F.
   - Then send ESC → all segs 7F, `o_led[8]` unchanged.
5. **Overrun**: two strobes 1 cycle apart ('5','6') → only '5' entered (count=1), `o_led[9]`=1.
   - The flag persists through CR and ESC and clears only on `i_rst`.
6. **Reset mid-update**: strobe '9' with `i_rst` high at E1 → count=0, segs 7F, `o_led`=0.
   - A following '9' + CR displays 10 on seg0.
